// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot decode of a requester index, same format as the 4-to-16 decode
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter16_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping 15->0.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   ffs;

  // Rotate right by ptr so the highest-priority requester lands in bit 0
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> ptr);

  // Fixed-priority find-first-set on the rotated vector (lowest bit wins)
  always_comb begin
    ffs = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) ffs = IDX_W'(i);
    end
  end

  assign found = |req_rot;
  // Undo the rotation; IDX_W-bit add wraps mod 16
  assign idx   = ffs + ptr;

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: 16 requesters share one resource; registered one-hot
// grant plus index. Optional hold limit enabled by defining RR_HOLD_LIMIT_EN.
module rr_arbiter16
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Reject hold limits outside the counter's range at elaboration
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter16: MAX_HOLD must be in 1..255");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_expire;
  logic             release_c;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RR_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  assign hold_expire = (hold_cnt == HOLD_LAST);

  // Count consecutive grant cycles; cleared while idle and on release, saturating
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE) || release_c) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  assign hold_expire = 1'b0;
`endif

  // Holder dropped its request, or used up its hold budget
  assign release_c = !req[gnt_idx] || hold_expire;

  // Arbitration FSM: grant from IDLE, release back to IDLE and advance the pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= GRANT;
            gnt_idx   <= pick_idx;
            gnt       <= onehot(pick_idx);
            gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (release_c) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one 16-way resource among 16 requesters.
- Produces a registered one-hot grant (16 lines, same one-hot format as the team's 4-to-16 decode) plus its 4-bit index.
- Fairness via a rotating priority pointer; an optional hold limit forces rotation.
- Sits between requesters and the shared resource's select lines.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles per requester before forced release; legal 1..255; used only with RR_HOLD_LIMIT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i = requester i.
- gnt  output  16  one-hot grant, registered; all zero when idle.
- gnt_idx  output  4  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  high while any grant is held; equals |gnt.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0.
  - Reset overrides everything, including a grant in progress; it takes effect on that edge.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay in IDLE.
  - Else at the edge: select the first set bit searching ptr, ptr+1, ... mod 16 (wrap 15→0).
  - Load gnt_idx with that index and gnt with its one-hot decode; set gnt_valid=1, hold_cnt=0; go to GRANT.
  - Latency: request sampled at edge N, grant visible after edge N (1 cycle).
- GRANT:
  - If req[gnt_idx]=0 at an edge (release): gnt=0, gnt_idx=0, gnt_valid=0, ptr=(old gnt_idx+1) mod 16, go to IDLE.
  - Otherwise hold the grant and increment hold_cnt (saturating 8-bit).
  - Requests from other requesters are ignored while granted.
- Arbitration gap: every release is followed by at least one IDLE cycle. No back-to-back grant on the same edge.
- Pointer wrap: a release of index 15 sets ptr=0.
- A lone requester may be re-granted after its idle cycle, regardless of ptr.
- Request glitches in IDLE: only the value sampled at the edge matters. There is no latching of past requests.
- Invariants: gnt is zero or exactly one-hot; gnt == decode(gnt_idx) whenever gnt_valid=1.

Optional Feature:
- Macro: RR_HOLD_LIMIT_EN.
- Defined:
  - In GRANT, if req[gnt_idx]=1 and hold_cnt==MAX_HOLD-1 at an edge, perform a forced release, identical to a normal release (ptr=idx+1, go to IDLE).
  - Maximum grant length is therefore MAX_HOLD cycles.
  - With MAX_HOLD=1, every grant lasts exactly 1 cycle.
- Undefined: no hold counter logic; a grant lasts until the requester drops req.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum (IDLE, GRANT);
  - constants N_REQ=16 and IDX_W=4;
  - hold-counter width HOLD_W=8.
- One sub-module: rr_pick.
  - Purely combinational rotating-priority search.
  - Inputs: req[15:0], ptr[3:0]. Outputs: found, idx[3:0].
  - Implemented by rotating req right by ptr, doing a fixed-priority find-first-set, then adding ptr back mod 16.
- Top level holds the FSM, registers, pointer, hold counter and one-hot decode.

Test Plan:
- Reset: drive req=16'hFFFF with rst=1 for 3 cycles → gnt=0, gnt_idx=0, gnt_valid=0 throughout. Release rst → next edge gnt=16'h0001, gnt_idx=0.
- Rotation: hold req=16'h0011; each grant holder drops req 2 cycles after its grant, then re-raises it.
  - Required grant order: idx 0, 4, 0, 4.
  - Exactly one idle cycle (gnt_valid=0) between grants.
- Wrap-around: hold req=16'h8001. Grant idx 15 and release it → ptr=0 → next grant idx 0. Then release idx 0 → ptr=1 → next grant idx 15.
- Mid-grant reset: grant idx 7 (req=16'h0080); assert rst for 1 cycle while req stays high.
  - gnt=0 on the reset edge.
  - After rst drops, ptr=0 search re-grants idx 7.
- Hold limit (RR_HOLD_LIMIT_EN, MAX_HOLD=3): req=16'h0006 held constant.
  - Grants: idx 1 for 3 cycles, 1 idle cycle, idx 2 for 3 cycles, 1 idle cycle, idx 1.
  - Without the macro: idx 1 held indefinitely.
- Invariants: 1000 cycles of random req, checked every cycle:
  - gnt is zero or one-hot;
  - gnt == 1<<gnt_idx when gnt_valid=1;
  - a grant is issued only to a requester whose req was set at the granting edge.
